// File: rtl/adam_mem_bridge.sv
// adam_mem_bridge: AXI-Lite slave to single-port SRAM bridge with ADAM pause handshake.
// Define ADAM_MEM_BRIDGE_ERR_EN to answer out-of-range addresses with SLVERR instead of wrapping.
module adam_mem_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    localparam int STRB_WIDTH = DATA_WIDTH / 8,
    localparam int IDX_W      = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pause_req,
    output logic                  pause_ack,
    input  logic [ADDR_WIDTH-1:0] aw_addr,
    input  logic                  aw_valid,
    output logic                  aw_ready,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [STRB_WIDTH-1:0] w_strb,
    input  logic                  w_valid,
    output logic                  w_ready,
    output logic [1:0]            b_resp,
    output logic                  b_valid,
    input  logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] ar_addr,
    input  logic                  ar_valid,
    output logic                  ar_ready,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic [1:0]            r_resp,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [IDX_W-1:0]      mem_addr,
    output logic [STRB_WIDTH-1:0] mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    localparam int OFS = $clog2(STRB_WIDTH);
    typedef enum logic [2:0] {PAUSED, IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, B_RESP, R_RESP} state_t;
    state_t                r_state, w_next;
    logic                  r_prio;
    logic [IDX_W-1:0]      r_idx;
    logic [STRB_WIDTH-1:0] r_be;
    logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
    logic [1:0]            r_bresp, r_rresp;
    logic                  w_wr_cand, w_wr_acc, w_rd_acc, w_aw_err, w_ar_err, w_unused;
`ifdef ADAM_MEM_BRIDGE_ERR_EN
    localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(MEM_DEPTH * STRB_WIDTH);
    assign w_aw_err = aw_addr >= LIMIT;
    assign w_ar_err = ar_addr >= LIMIT;
`else
    assign w_aw_err = 1'b0;
    assign w_ar_err = 1'b0;
`endif
    assign w_unused  = ^{aw_addr, ar_addr};
    // r_prio=1 favours the write candidate; it flips on every accepted transaction
    assign w_wr_cand = aw_valid && w_valid;
    assign w_wr_acc  = r_state == IDLE && !pause_req && w_wr_cand && (!ar_valid || r_prio);
    assign w_rd_acc  = r_state == IDLE && !pause_req && ar_valid && (!w_wr_cand || !r_prio);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= PAUSED;
        else        r_state <= w_next;
    end
    always_comb begin
        w_next    = r_state;
        pause_ack = r_state == PAUSED;
        aw_ready  = w_wr_acc;
        w_ready   = w_wr_acc;
        ar_ready  = w_rd_acc;
        b_valid   = r_state == B_RESP;
        r_valid   = r_state == R_RESP;
        mem_req   = r_state == WR_ISSUE || r_state == RD_ISSUE;
        mem_we    = r_state == WR_ISSUE;
        mem_addr  = (r_state == WR_ISSUE || r_state == RD_ISSUE) ? r_idx : '0;
        mem_be    = r_state == WR_ISSUE ? r_be : '0;
        mem_wdata = r_state == WR_ISSUE ? r_wdata : '0;
        case (r_state)
            PAUSED:   w_next = pause_req ? PAUSED : IDLE;
            IDLE:     w_next = pause_req ? PAUSED :
                               w_wr_acc  ? (w_aw_err ? B_RESP : WR_ISSUE) :
                               w_rd_acc  ? (w_ar_err ? R_RESP : RD_ISSUE) : IDLE;
            WR_ISSUE: w_next = B_RESP;
            RD_ISSUE: w_next = RD_WAIT;
            RD_WAIT:  w_next = R_RESP;
            B_RESP:   w_next = b_ready ? IDLE : B_RESP;
            R_RESP:   w_next = r_ready ? IDLE : R_RESP;
            default:  w_next = PAUSED;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio  <= 1'b0;
            r_idx   <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_bresp <= 2'b00;
            r_rresp <= 2'b00;
        end else begin
            if (w_wr_acc || w_rd_acc) r_prio <= ~r_prio;
            if (w_wr_acc) begin
                r_idx   <= aw_addr[OFS +: IDX_W];
                r_be    <= w_strb;
                r_wdata <= w_data;
                r_bresp <= w_aw_err ? 2'b10 : 2'b00;
            end
            if (w_rd_acc) begin
                r_idx   <= ar_addr[OFS +: IDX_W];
                r_rresp <= w_ar_err ? 2'b10 : 2'b00;
                if (w_ar_err) r_rdata <= '0;
            end
            if (r_state == RD_WAIT) r_rdata <= mem_rdata;
        end
    end
    assign b_resp = r_bresp;
    assign r_resp = r_rresp;
    assign r_data = r_rdata;
endmodule

// File: tb/tb_adam_mem_bridge.sv
// tb_adam_mem_bridge: directed bench for adam_mem_bridge with a behavioural SRAM model.
module tb_adam_mem_bridge;
    logic        clk = 1'b0, rst_n = 1'b0, pause_req = 1'b1;
    logic [31:0] aw_addr = '0, ar_addr = '0, w_data = '0;
    logic [3:0]  w_strb = '0;
    logic        aw_valid = 1'b1, w_valid = 1'b1, ar_valid = 1'b1, b_ready = 1'b0, r_ready = 1'b0;
    logic        aw_ready, w_ready, ar_ready, b_valid, r_valid, pause_ack;
    logic [1:0]  b_resp, r_resp;
    logic [31:0] r_data, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_req, mem_we;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem [1024] = '{default: 32'h0};
    int          n_checks = 0, n_errors = 0, t;
    always #5 clk = ~clk;
    adam_mem_bridge dut (
        .clk(clk), .rst_n(rst_n), .pause_req(pause_req), .pause_ack(pause_ack),
        .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
        .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else mem_rdata <= mem[mem_addr];
        end
    end
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask
    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [9:0] idx, input int exp_req,
                            input int exp_b, input logic [1:0] exp_resp);
        int k, req_at, b_at;
        @(posedge clk); #1;
        aw_addr = addr; w_data = data; w_strb = strb; aw_valid = 1'b1; w_valid = 1'b1; b_ready = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!aw_ready && k < 20);
        check({tag, " aw/w ready"}, 32'({aw_ready, w_ready}), 32'd3);
        @(posedge clk); #1;
        aw_valid = 1'b0; w_valid = 1'b0;
        req_at = -1; b_at = -1;
        for (int i = 1; i <= 20 && b_at < 0; i++) begin
            @(negedge clk);
            if (mem_req && req_at < 0) begin
                req_at = i;
                check({tag, " mem we/be/addr"}, 32'({mem_we, mem_be, mem_addr}), 32'({1'b1, strb, idx}));
                check({tag, " mem_wdata"}, mem_wdata, data);
            end
            if (b_valid) b_at = i;
        end
        check({tag, " mem_req latency"}, 32'(req_at), 32'(exp_req));
        check({tag, " b_valid latency"}, 32'(b_at), 32'(exp_b));
        check({tag, " b_resp"}, 32'(b_resp), 32'(exp_resp));
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, " b_valid drop"}, 32'(b_valid), 32'd0);
    endtask
    task automatic do_read(input string tag, input logic [31:0] addr, input logic [9:0] idx,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp,
                           input int exp_req, input int exp_r);
        int k, req_at, r_at;
        @(posedge clk); #1;
        ar_addr = addr; ar_valid = 1'b1; r_ready = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!ar_ready && k < 20);
        check({tag, " ar_ready"}, 32'(ar_ready), 32'd1);
        @(posedge clk); #1;
        ar_valid = 1'b0;
        req_at = -1; r_at = -1;
        for (int i = 1; i <= 20 && r_at < 0; i++) begin
            @(negedge clk);
            if (mem_req && req_at < 0) begin
                req_at = i;
                check({tag, " mem we/addr"}, 32'({mem_we, mem_addr}), 32'({1'b0, idx}));
            end
            if (r_valid) r_at = i;
        end
        check({tag, " mem_req latency"}, 32'(req_at), 32'(exp_req));
        check({tag, " r_valid latency"}, 32'(r_at), 32'(exp_r));
        check({tag, " r_data"}, r_data, exp_data);
        check({tag, " r_resp"}, 32'(r_resp), 32'(exp_resp));
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, " r_valid drop"}, 32'(r_valid), 32'd0);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
    initial begin
        repeat (2) @(negedge clk);
        check("reset ack/valids/req", 32'({pause_ack, b_valid, r_valid, mem_req}), 32'b1000);
        check("reset r_data", r_data, 32'h0);
        check("reset resps", 32'({b_resp, r_resp}), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("paused readies", 32'({aw_ready, w_ready, ar_ready}), 32'd0);
        check("paused ack", 32'(pause_ack), 32'd1);
        @(posedge clk); #1;
        aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0; pause_req = 1'b0;
        @(negedge clk);
        check("release ack same cycle", 32'(pause_ack), 32'd1);
        @(negedge clk);
        check("release ack next cycle", 32'(pause_ack), 32'd0);
        do_write("wr beef", 32'h10, 32'hDEADBEEF, 4'b0011, 10'd4, 1, 2, 2'b00);
        do_read("rd beef", 32'h10, 10'd4, 32'h0000BEEF, 2'b00, 1, 3);
        do_read("rd low bits", 32'h13, 10'd4, 32'h0000BEEF, 2'b00, 1, 3);
        @(posedge clk); #1;
        aw_addr = 32'h20; w_data = 32'h11223344; w_strb = 4'hF; aw_valid = 1'b1; w_valid = 1'b0; b_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("lone aw readies", 32'({aw_ready, w_ready}), 32'd0);
        end
        @(posedge clk); #1;
        w_valid = 1'b1;
        @(negedge clk);
        check("aw+w joint ready", 32'({aw_ready, w_ready}), 32'd3);
        @(posedge clk); #1;
        aw_valid = 1'b0; w_valid = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!b_valid && t < 20);
        check("joint write b_valid", 32'(b_valid), 32'd1);
        @(posedge clk); #1;
        ar_addr = 32'h10; ar_valid = 1'b1; r_ready = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!ar_ready && t < 20);
        @(posedge clk); #1;
        ar_valid = 1'b0;
        @(negedge clk);
        check("abort mem_req before", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort mem_req/ack", 32'({mem_req, pause_ack}), 32'b01);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort no response", 32'({r_valid, pause_ack}), 32'b00);
        @(posedge clk); #1;
        aw_addr = 32'h20; w_data = 32'h55667788; w_strb = 4'hF; ar_addr = 32'h10;
        aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1; b_ready = 1'b1; r_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            t = 0;
            do begin @(negedge clk); t++; end while (!aw_ready && !ar_ready && t < 20);
            check($sformatf("rr accept %0d {aw,ar}", n), 32'({aw_ready, ar_ready}), (n % 2 == 0) ? 32'd1 : 32'd2);
            @(posedge clk); #1;
            if (n == 3) begin aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0; end
            t = 0;
            do begin @(negedge clk); t++; end while (!b_valid && !r_valid && t < 20);
            check($sformatf("rr resp %0d {b,r}", n), 32'({b_valid, r_valid}), (n % 2 == 0) ? 32'd1 : 32'd2);
            if (n % 2 == 0) check($sformatf("rr rdata %0d", n), r_data, 32'h0000BEEF);
            @(posedge clk); #1;
        end
        ar_addr = 32'h10; ar_valid = 1'b1; r_ready = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!ar_ready && t < 20);
        check("pause ar_ready", 32'(ar_ready), 32'd1);
        @(posedge clk); #1;
        pause_req = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!r_valid && t < 20);
        check("pause r_valid/ack", 32'({r_valid, pause_ack}), 32'b10);
        check("pause r_data", r_data, 32'h0000BEEF);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("pause hold r_valid/ar_ready", 32'({r_valid, ar_ready}), 32'b10);
        end
        @(posedge clk); #1;
        r_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check("pause idle {ar_ready,ack,r_valid}", 32'({ar_ready, pause_ack, r_valid}), 32'd0);
        @(negedge clk);
        check("pause entered {ar_ready,ack}", 32'({ar_ready, pause_ack}), 32'b01);
        @(posedge clk); #1;
        ar_valid = 1'b0; pause_req = 1'b0;
        repeat (2) @(negedge clk);
        do_write("wr word0", 32'h0, 32'hCAFEF00D, 4'hF, 10'd0, 1, 2, 2'b00);
`ifdef ADAM_MEM_BRIDGE_ERR_EN
        do_read("oor rd", 32'h1000, 10'd0, 32'h0, 2'b10, -1, 1);
        do_write("oor wr", 32'h1000, 32'hFFFFFFFF, 4'hF, 10'd0, -1, 1, 2'b10);
`else
        do_read("wrap rd", 32'h1000, 10'd0, 32'hCAFEF00D, 2'b00, 1, 3);
`endif
        do_read("rd word0", 32'h0, 10'd0, 32'hCAFEF00D, 2'b00, 1, 3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
